// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level controller: runs START/STOP/WRITE/READ as four tick-timed phases on open-drain SCL/SDA.
// Define I2C_CLK_STRETCH_EN to let a slave holding SCL low freeze the current phase.
module i2c_bit_ctrl #(
  parameter int FILTER_LEN = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  output logic       TimerStart,
  input  logic [1:0] Cmd,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic       Din,
  output logic       Dout,
  output logic       Done,
  output logic       SclOen,
  output logic       SdaOen,
  input  logic       SclIn,
  input  logic       SdaIn
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A    = 3'd1,
    ST_B    = 3'd2,
    ST_C    = 3'd3,
    ST_D    = 3'd4
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

`ifdef I2C_CLK_STRETCH_EN
  localparam logic STRETCH_EN = 1'b1;
`else
  localparam logic STRETCH_EN = 1'b0;
`endif

  state_t                state_r, state_nx;
  logic [1:0]            cmd_r, cmd_nx;
  logic                  din_r, din_nx;
  logic                  done_r, done_nx;
  logic                  dout_r, dout_nx;
  logic                  tstart_r, tstart_nx;
  logic                  scl_oen_r, sda_oen_r;
  logic [1:0]            lines_nx;
  logic [FILTER_LEN-1:0] scl_sync_r, sda_sync_r;
  logic                  stretch_s, advance_s;

  // (SCL, SDA) release pattern for a phase; IDLE keeps whatever the last command left on the bus.
  function automatic logic [1:0] phase_lines(input logic [1:0] cmd, input logic din,
                                             input state_t st, input logic [1:0] hold);
    logic [1:0] l;
    l = hold;
    case (cmd)
      CMD_START:
        case (st)
          ST_A, ST_B: l = 2'b11;
          ST_C:       l = 2'b10;
          ST_D:       l = 2'b00;
          default:    l = hold;
        endcase
      CMD_STOP:
        case (st)
          ST_A:       l = 2'b00;
          ST_B, ST_C: l = 2'b10;
          ST_D:       l = 2'b11;
          default:    l = hold;
        endcase
      CMD_WRITE:
        case (st)
          ST_A, ST_D: l = {1'b0, din};
          ST_B, ST_C: l = {1'b1, din};
          default:    l = hold;
        endcase
      default:
        case (st)
          ST_A, ST_D: l = 2'b01;
          ST_B, ST_C: l = 2'b11;
          default:    l = hold;
        endcase
    endcase
    return l;
  endfunction

  // A slave may only stretch while we are releasing SCL and it still reads low.
  assign stretch_s = STRETCH_EN & scl_oen_r & ~scl_sync_r[FILTER_LEN-1] & (state_r != ST_IDLE);
  assign advance_s = Tick & ~stretch_s;
  assign lines_nx  = phase_lines(cmd_r, din_r, state_r, {scl_oen_r, sda_oen_r});

  // Synchronizers for the asynchronous bus levels
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      scl_sync_r <= {FILTER_LEN{1'b1}};
      sda_sync_r <= {FILTER_LEN{1'b1}};
    end else begin
      scl_sync_r <= {scl_sync_r[FILTER_LEN-2:0], SclIn};
      sda_sync_r <= {sda_sync_r[FILTER_LEN-2:0], SdaIn};
    end
  end

  // Next-state and registered-output logic for the phase sequencer
  always_comb begin
    state_nx  = state_r;
    cmd_nx    = cmd_r;
    din_nx    = din_r;
    done_nx   = 1'b0;
    dout_nx   = dout_r;
    tstart_nx = stretch_s;
    case (state_r)
      ST_IDLE: begin
        if (CmdValid) begin
          state_nx  = ST_A;
          cmd_nx    = Cmd;
          din_nx    = Din;
          tstart_nx = 1'b0;
        end else begin
          tstart_nx = 1'b1;
        end
      end
      ST_A: begin
        if (advance_s) state_nx = ST_B;
        else           state_nx = ST_A;
      end
      ST_B: begin
        if (advance_s) state_nx = ST_C;
        else           state_nx = ST_B;
      end
      ST_C: begin
        if (advance_s) begin
          state_nx = ST_D;
          if (cmd_r == 2'b11) dout_nx = sda_sync_r[FILTER_LEN-1];
          else                dout_nx = dout_r;
        end else begin
          state_nx = ST_C;
        end
      end
      ST_D: begin
        if (advance_s) begin
          state_nx  = ST_IDLE;
          done_nx   = 1'b1;
          tstart_nx = 1'b1;
        end else begin
          state_nx  = ST_D;
        end
      end
      default: begin
        state_nx  = ST_IDLE;
        tstart_nx = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r   <= ST_IDLE;
      cmd_r     <= 2'b00;
      din_r     <= 1'b0;
      done_r    <= 1'b0;
      dout_r    <= 1'b0;
      tstart_r  <= 1'b1;
      scl_oen_r <= 1'b1;
      sda_oen_r <= 1'b1;
    end else begin
      state_r   <= state_nx;
      cmd_r     <= cmd_nx;
      din_r     <= din_nx;
      done_r    <= done_nx;
      dout_r    <= dout_nx;
      tstart_r  <= tstart_nx;
      scl_oen_r <= lines_nx[1];
      sda_oen_r <= lines_nx[0];
    end
  end

  assign CmdReady   = (state_r == ST_IDLE);
  assign TimerStart = tstart_r;
  assign Done       = done_r;
  assign Dout       = dout_r;
  assign SclOen     = scl_oen_r;
  assign SdaOen     = sda_oen_r;

endmodule
